// File: rtl/exe_operand_stage_pkg.sv
// Shared constants for the ID->EXE operand stage: datapath defaults and forwarding-select codes.
package exe_operand_stage_pkg;

    localparam int unsigned DEF_WORD_LEN        = 32;
    localparam int unsigned DEF_REG_ADDRESS_LEN = 4;
    localparam int unsigned DEF_CNT_W           = 16;

    localparam logic [1:0] FW_SEL_REG  = 2'b00;
    localparam logic [1:0] FW_SEL_MEM  = 2'b01;
    localparam logic [1:0] FW_SEL_WB   = 2'b10;
    localparam logic [1:0] FW_SEL_RSVD = 2'b11;

endpackage

// File: rtl/exe_operand_stage_if.sv
// ID-side fields, forwarding inputs and registered EXE-side fields of the operand stage.
interface exe_operand_stage_if #(
    parameter int unsigned WORD_LEN        = 32,
    parameter int unsigned REG_ADDRESS_LEN = 4
);
    logic                       id_valid;
    logic [WORD_LEN-1:0]        id_pc;
    logic [WORD_LEN-1:0]        id_val_rn;
    logic [WORD_LEN-1:0]        id_val_rm;
    logic [11:0]                id_shift_operand;
    logic                       id_imm;
    logic [23:0]                id_signed_imm24;
    logic [3:0]                 id_exe_cmd;
    logic                       id_mem_r_en;
    logic                       id_mem_w_en;
    logic                       id_wb_en;
    logic                       id_s;
    logic                       id_b;
    logic [REG_ADDRESS_LEN-1:0] id_dst;
    logic [REG_ADDRESS_LEN-1:0] id_src1;
    logic [REG_ADDRESS_LEN-1:0] id_src2;
    logic [3:0]                 id_status;
    logic [1:0]                 sel_src1;
    logic [1:0]                 sel_src2;
    logic [WORD_LEN-1:0]        mem_alu_res;
    logic [WORD_LEN-1:0]        wb_value;

    logic                       exe_valid;
    logic [WORD_LEN-1:0]        exe_pc;
    logic [WORD_LEN-1:0]        exe_val_rn;
    logic [WORD_LEN-1:0]        exe_val_rm;
    logic [11:0]                exe_shift_operand;
    logic                       exe_imm;
    logic [23:0]                exe_signed_imm24;
    logic [3:0]                 exe_exe_cmd;
    logic                       exe_mem_r_en;
    logic                       exe_mem_w_en;
    logic                       exe_wb_en;
    logic                       exe_s;
    logic                       exe_b;
    logic [REG_ADDRESS_LEN-1:0] exe_dst;
    logic [REG_ADDRESS_LEN-1:0] exe_src1;
    logic [REG_ADDRESS_LEN-1:0] exe_src2;
    logic [3:0]                 exe_status;
    logic [WORD_LEN-1:0]        exe_op1;
    logic [WORD_LEN-1:0]        exe_store_val;

    modport master (
        output id_valid, id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm,
               id_signed_imm24, id_exe_cmd, id_mem_r_en, id_mem_w_en, id_wb_en, id_s, id_b,
               id_dst, id_src1, id_src2, id_status, sel_src1, sel_src2, mem_alu_res, wb_value,
        input  exe_valid, exe_pc, exe_val_rn, exe_val_rm, exe_shift_operand, exe_imm,
               exe_signed_imm24, exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_s,
               exe_b, exe_dst, exe_src1, exe_src2, exe_status, exe_op1, exe_store_val
    );

    modport slave (
        input  id_valid, id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm,
               id_signed_imm24, id_exe_cmd, id_mem_r_en, id_mem_w_en, id_wb_en, id_s, id_b,
               id_dst, id_src1, id_src2, id_status, sel_src1, sel_src2, mem_alu_res, wb_value,
        output exe_valid, exe_pc, exe_val_rn, exe_val_rm, exe_shift_operand, exe_imm,
               exe_signed_imm24, exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_s,
               exe_b, exe_dst, exe_src1, exe_src2, exe_status, exe_op1, exe_store_val
    );
endinterface

// File: rtl/exe_operand_stage_fwd_mux3.sv
// Three-way forwarding mux: register value, MEM-stage result or WB-stage value.
module exe_operand_stage_fwd_mux3
    import exe_operand_stage_pkg::*;
#(
    parameter int unsigned WORD_LEN = DEF_WORD_LEN
) (
    input  logic [1:0]          sel,
    input  logic [WORD_LEN-1:0] reg_val,
    input  logic [WORD_LEN-1:0] mem_val,
    input  logic [WORD_LEN-1:0] wb_val,
    output logic [WORD_LEN-1:0] y
);

    always_comb begin
        unique case (sel)
            FW_SEL_MEM:              y = mem_val;
            FW_SEL_WB:               y = wb_val;
            FW_SEL_REG, FW_SEL_RSVD: y = reg_val;
            default:                 y = reg_val;
        endcase
    end

endmodule

// File: rtl/exe_operand_stage.sv
// ID->EXE pipeline register with freeze/flush, operand forwarding and stall/flush event counters.
module exe_operand_stage
    import exe_operand_stage_pkg::*;
#(
    parameter int unsigned WORD_LEN        = DEF_WORD_LEN,
    parameter int unsigned REG_ADDRESS_LEN = DEF_REG_ADDRESS_LEN,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    exe_operand_stage_if.slave bus,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef struct packed {
        logic                       valid;
        logic [WORD_LEN-1:0]        pc;
        logic [WORD_LEN-1:0]        val_rn;
        logic [WORD_LEN-1:0]        val_rm;
        logic [11:0]                shift_operand;
        logic                       imm;
        logic [23:0]                signed_imm24;
        logic [3:0]                 exe_cmd;
        logic                       mem_r_en;
        logic                       mem_w_en;
        logic                       wb_en;
        logic                       s;
        logic                       b;
        logic [REG_ADDRESS_LEN-1:0] dst;
        logic [REG_ADDRESS_LEN-1:0] src1;
        logic [REG_ADDRESS_LEN-1:0] src2;
        logic [3:0]                 status;
    } stage_t;

    stage_t            stage_d, stage_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!freeze) begin
            stage_d.valid         = bus.id_valid;
            stage_d.pc            = bus.id_pc;
            stage_d.val_rn        = bus.id_val_rn;
            stage_d.val_rm        = bus.id_val_rm;
            stage_d.shift_operand = bus.id_shift_operand;
            stage_d.imm           = bus.id_imm;
            stage_d.signed_imm24  = bus.id_signed_imm24;
            stage_d.exe_cmd       = bus.id_exe_cmd;
            stage_d.dst           = bus.id_dst;
            stage_d.src1          = bus.id_src1;
            stage_d.src2          = bus.id_src2;
            stage_d.status        = bus.id_status;
            // An invalid instruction must not cause side effects downstream.
            stage_d.mem_r_en      = bus.id_mem_r_en & bus.id_valid;
            stage_d.mem_w_en      = bus.id_mem_w_en & bus.id_valid;
            stage_d.wb_en         = bus.id_wb_en & bus.id_valid;
            stage_d.s             = bus.id_s & bus.id_valid;
            stage_d.b             = bus.id_b & bus.id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stage_q <= stage_d;
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if (freeze && !flush && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    assign bus.exe_valid         = stage_q.valid;
    assign bus.exe_pc            = stage_q.pc;
    assign bus.exe_val_rn        = stage_q.val_rn;
    assign bus.exe_val_rm        = stage_q.val_rm;
    assign bus.exe_shift_operand = stage_q.shift_operand;
    assign bus.exe_imm           = stage_q.imm;
    assign bus.exe_signed_imm24  = stage_q.signed_imm24;
    assign bus.exe_exe_cmd       = stage_q.exe_cmd;
    assign bus.exe_mem_r_en      = stage_q.mem_r_en;
    assign bus.exe_mem_w_en      = stage_q.mem_w_en;
    assign bus.exe_wb_en         = stage_q.wb_en;
    assign bus.exe_s             = stage_q.s;
    assign bus.exe_b             = stage_q.b;
    assign bus.exe_dst           = stage_q.dst;
    assign bus.exe_src1          = stage_q.src1;
    assign bus.exe_src2          = stage_q.src2;
    assign bus.exe_status        = stage_q.status;

    exe_operand_stage_fwd_mux3 #(.WORD_LEN(WORD_LEN)) u_fwd_op1 (
        .sel     (bus.sel_src1),
        .reg_val (stage_q.val_rn),
        .mem_val (bus.mem_alu_res),
        .wb_val  (bus.wb_value),
        .y       (bus.exe_op1)
    );

    exe_operand_stage_fwd_mux3 #(.WORD_LEN(WORD_LEN)) u_fwd_store (
        .sel     (bus.sel_src2),
        .reg_val (stage_q.val_rm),
        .mem_val (bus.mem_alu_res),
        .wb_val  (bus.wb_value),
        .y       (bus.exe_store_val)
    );

endmodule
